// File: rtl/cpu_param.sv
// Parametrised stripe CPU: two-phase fetch/execute core for a synchronous program ROM,
// with valid/ack input channels, strobed output channels, branches and HALT.
//
// state  | meaning
// FETCH  | rom_value is being read for pc (one cycle of ROM latency)
// EXEC   | decode and commit rom_value; stays here while IN waits for in_valid
// HALTED | core stopped, all state frozen until reset
module cpu_param #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int NIN    = 2,
    parameter int NOUT   = 2,
    parameter int ADDR_W = 8,
    localparam int RW     = $clog2(NREGS),
    localparam int MAXCH  = (NIN > NOUT) ? ((NIN > 2) ? NIN : 2) : ((NOUT > 2) ? NOUT : 2),
    localparam int CW     = $clog2(MAXCH),
    localparam int INSN_W = 3 + 3*RW + DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSN_W-1:0]      rom_value,
    input  logic [NIN*DATA_W-1:0]  inputs,
    input  logic [NIN-1:0]         in_valid,
    output logic [NIN-1:0]         in_ack,
    output logic [NOUT*DATA_W-1:0] outputs,
    output logic [NOUT-1:0]        out_valid,
    output logic                   halt,
    output logic [ADDR_W-1:0]      pc,
    output logic [ADDR_W-1:0]      rom_address,
    output logic [NREGS*DATA_W-1:0] regs
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [2:0] OP_IN   = 3'd0;
    localparam logic [2:0] OP_OUT  = 3'd1;
    localparam logic [2:0] OP_MATH = 3'd2;
    localparam logic [2:0] OP_IMM  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_BEQZ = 3'd5;
    localparam logic [2:0] OP_BNEZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    logic [1:0]        state;
    logic [DATA_W-1:0] rf   [NREGS];
    logic [DATA_W-1:0] outq [NOUT];

    logic [2:0]        op;
    logic [RW-1:0]     rd, rs1, rs2;
    logic [DATA_W-1:0] imm;
    logic [CW-1:0]     ch;
    logic [DATA_W-1:0] a, b, alu;
    logic              in_hit, in_rdy, stall, take;
    logic [DATA_W-1:0] in_data;
    logic [NIN-1:0]    ack_vec;
    logic [ADDR_W-1:0] pc_next;

    assign op  = rom_value[2:0];
    assign rd  = rom_value[3 +: RW];
    assign rs1 = rom_value[3 + RW +: RW];
    assign rs2 = rom_value[3 + 2*RW +: RW];
    assign imm = rom_value[3 + 3*RW +: DATA_W];
    assign ch  = rs2[CW-1:0];
    assign a   = rf[rs1];
    assign b   = rf[rs2];

    // A channel outside 0..NIN-1 never matches, so IN reads 0 and never stalls
    always_comb begin
        in_hit  = 1'b0;
        in_rdy  = 1'b0;
        in_data = '0;
        ack_vec = '0;
        for (int c = 0; c < NIN; c++) begin
            if (ch == CW'(c)) begin
                in_hit     = 1'b1;
                in_rdy     = in_valid[c];
                in_data    = inputs[c*DATA_W +: DATA_W];
                ack_vec[c] = in_valid[c];
            end
        end
    end

    always_comb begin
        case (imm[1:0])
            2'd0:    alu = a + b;
            2'd1:    alu = a - b;
            2'd2:    alu = a & b;
            default: alu = a ^ b;
        endcase
    end

    always_comb begin
        case (op)
            OP_JMP:  take = 1'b1;
            OP_BEQZ: take = (a == '0);
            OP_BNEZ: take = (a != '0);
            default: take = 1'b0;
        endcase
    end

    assign stall   = (op == OP_IN) && in_hit && !in_rdy;
    assign pc_next = take ? imm[ADDR_W-1:0] : pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= '0;
            halt      <= 1'b0;
            in_ack    <= '0;
            out_valid <= '0;
            for (int r = 0; r < NREGS; r++) rf[r] <= '0;
            for (int c = 0; c < NOUT; c++) outq[c] <= '0;
        end else begin
            in_ack    <= '0;
            out_valid <= '0;
            case (state)
                FETCH: state <= EXEC;
                EXEC: begin
                    if (op == OP_HALT) begin
                        halt  <= 1'b1;
                        state <= HALTED;
                    end else if (!stall) begin
                        pc    <= pc_next;
                        state <= FETCH;
                        case (op)
                            OP_IN: begin
                                rf[rd] <= in_data;
                                in_ack <= ack_vec;
                            end
                            OP_OUT: begin
                                for (int c = 0; c < NOUT; c++) begin
                                    if (ch == CW'(c)) begin
                                        outq[c]      <= a;
                                        out_valid[c] <= 1'b1;
                                    end
                                end
                            end
                            OP_MATH: rf[rd] <= alu;
                            OP_IMM:  rf[rd] <= imm;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_address = pc;

    for (genvar r = 0; r < NREGS; r++) begin : g_regs
        assign regs[r*DATA_W +: DATA_W] = rf[r];
    end
    for (genvar c = 0; c < NOUT; c++) begin : g_outs
        assign outputs[c*DATA_W +: DATA_W] = outq[c];
    end

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: default-width instance for the instruction set,
// handshakes and reset, plus a 12-bit/8-register instance for reparametrisation.
module tb_cpu_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: defaults ----------------
    logic        rst_a = 1'b0;
    logic [16:0] romv_a;
    logic [15:0] inputs_a = '0;
    logic [1:0]  inv_a = '0;
    logic [1:0]  ack_a, ov_a;
    logic [15:0] outs_a;
    logic        halt_a;
    logic [7:0]  pc_a, ra_a;
    logic [31:0] regs_a;
    logic [16:0] rom_a [256];

    always_ff @(posedge clk) romv_a <= rom_a[ra_a];

    cpu_param dut_a (
        .clk(clk), .rst_n(rst_a), .rom_value(romv_a), .inputs(inputs_a),
        .in_valid(inv_a), .in_ack(ack_a), .outputs(outs_a), .out_valid(ov_a),
        .halt(halt_a), .pc(pc_a), .rom_address(ra_a), .regs(regs_a)
    );

    // ---------------- instance B: wide ----------------
    logic        rst_nb = 1'b0;
    logic [23:0] romv_b;
    logic [47:0] inputs_b = '0;
    logic [3:0]  inv_b = '0;
    logic [3:0]  ack_b, ov_b;
    logic [47:0] outs_b;
    logic        halt_b;
    logic [7:0]  pc_b, ra_b;
    logic [95:0] regs_b;
    logic [23:0] rom_b [256];

    always_ff @(posedge clk) romv_b <= rom_b[ra_b];

    cpu_param #(.DATA_W(12), .NREGS(8), .NIN(4), .NOUT(4), .ADDR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_nb), .rom_value(romv_b), .inputs(inputs_b),
        .in_valid(inv_b), .in_ack(ack_b), .outputs(outs_b), .out_valid(ov_b),
        .halt(halt_b), .pc(pc_b), .rom_address(ra_b), .regs(regs_b)
    );

    function automatic logic [16:0] ea(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        return {8'(imm), 2'(rs2), 2'(rs1), 2'(rd), 3'(op)};
    endfunction

    function automatic logic [23:0] eb(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        return {12'(imm), 3'(rs2), 3'(rs1), 3'(rd), 3'(op)};
    endfunction

    task automatic clear_a();
        for (int i = 0; i < 256; i++) rom_a[i] = ea(7, 0, 0, 0, 0);
    endtask

    task automatic reset_a();
        @(negedge clk) rst_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_halt_a(output int cyc);
        cyc = 0;
        while (!halt_a && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        // defaults: IMM/IMM/ADD/HALT
        clear_a();
        rom_a[0] = ea(3, 1, 0, 0, 5);
        rom_a[1] = ea(3, 2, 0, 0, 3);
        rom_a[2] = ea(2, 3, 1, 2, 0);
        reset_a();
        check("rst_pc", pc_a, 0);
        check("rst_romaddr", ra_a, 0);
        check("rst_halt", halt_a, 0);
        check("rst_regs", regs_a, 0);
        check("rst_outs", outs_a, 0);
        check("rst_ack_ov", {ack_a, ov_a}, 0);
        run_halt_a(cyc);
        check("def_cycles", cyc, 8);
        check("def_regs", regs_a, {8'd8, 8'd3, 8'd5, 8'd0});
        check("def_pc", pc_a, 3);
        step(4);
        check("halted_pc", pc_a, 3);
        check("halted_state", {halt_a, ack_a, ov_a, regs_a}, {1'b1, 4'b0, 8'd8, 8'd3, 8'd5, 8'd0});

        // SUB underflow, ADD overflow
        clear_a();
        rom_a[0] = ea(3, 1, 0, 0, 8'h02);
        rom_a[1] = ea(3, 2, 0, 0, 8'h05);
        rom_a[2] = ea(2, 0, 1, 2, 1);
        rom_a[3] = ea(3, 1, 0, 0, 8'hFF);
        rom_a[4] = ea(3, 2, 0, 0, 8'h01);
        rom_a[5] = ea(2, 3, 1, 2, 0);
        reset_a();
        run_halt_a(cyc);
        check("sub_add_regs", regs_a, {8'h00, 8'h01, 8'hFF, 8'hFD});

        // AND, XOR with rd == rs2
        clear_a();
        rom_a[0] = ea(3, 1, 0, 0, 8'hF0);
        rom_a[1] = ea(3, 2, 0, 0, 8'h3C);
        rom_a[2] = ea(2, 0, 1, 2, 2);
        rom_a[3] = ea(2, 2, 1, 2, 3);
        reset_a();
        run_halt_a(cyc);
        check("and_xor_regs", regs_a, {8'h00, 8'hCC, 8'hF0, 8'h30});

        // countdown loop with BNEZ, then BEQZ taken and JMP
        clear_a();
        rom_a[0] = ea(3, 1, 0, 0, 3);
        rom_a[1] = ea(3, 2, 0, 0, 1);
        rom_a[2] = ea(2, 1, 1, 2, 1);
        rom_a[3] = ea(2, 0, 0, 2, 0);
        rom_a[4] = ea(6, 0, 1, 0, 2);
        rom_a[5] = ea(5, 0, 1, 0, 7);
        rom_a[7] = ea(4, 0, 0, 0, 9);
        reset_a();
        run_halt_a(cyc);
        check("loop_cycles", cyc, 28);
        check("loop_regs", regs_a, {8'h00, 8'h01, 8'h00, 8'h03});
        check("loop_pc", pc_a, 9);

        // pc wrap from 0xFF, BEQZ not taken on nonzero
        clear_a();
        rom_a[0]   = ea(5, 0, 3, 0, 8'hFF);
        rom_a[255] = ea(3, 3, 0, 0, 8'h11);
        rom_a[1]   = ea(7, 0, 0, 0, 0);
        reset_a();
        step(2);
        check("wrap_pc_ff", pc_a, 8'hFF);
        step(2);
        check("wrap_pc_00", {ra_a, pc_a}, 16'h0000);
        run_halt_a(cyc);
        check("wrap_end", {cyc[7:0], pc_a, regs_a[31:24]}, {8'd4, 8'd1, 8'h11});

        // IN handshake with a 5-cycle stall on ch1
        clear_a();
        rom_a[0] = ea(0, 1, 0, 1, 0);
        inputs_a = {8'h00, 8'h55};
        inv_a    = 2'b01;
        reset_a();
        step(1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("in_stall", {pc_a, ack_a, regs_a[15:8]}, {8'd0, 2'b00, 8'h00});
        end
        inputs_a[15:8] = 8'hA7;
        inv_a          = 2'b11;
        step(1);
        check("in_ack_pulse", ack_a, 2'b10);
        check("in_data", {pc_a, regs_a}, {8'd1, 8'h00, 8'h00, 8'hA7, 8'h00});
        step(1);
        check("in_ack_drop", ack_a, 2'b00);
        inv_a = 2'b00;

        // OUT strobes on ch0 and ch1
        clear_a();
        rom_a[0] = ea(3, 1, 0, 0, 8'h42);
        rom_a[1] = ea(1, 0, 1, 0, 0);
        rom_a[2] = ea(1, 0, 1, 1, 0);
        reset_a();
        step(3);
        check("out_pre", {ov_a, outs_a}, {2'b00, 16'h0000});
        step(1);
        check("out0_strobe", {ov_a, outs_a}, {2'b01, 16'h0042});
        step(1);
        check("out0_hold", {ov_a, outs_a}, {2'b00, 16'h0042});
        step(1);
        check("out1_strobe", {ov_a, outs_a}, {2'b10, 16'h4242});
        step(1);
        check("out1_drop", ov_a, 2'b00);
        run_halt_a(cyc);
        check("out_halt", {halt_a, ov_a, pc_a}, {1'b1, 2'b00, 8'd3});

        // reset while stalled in IN
        clear_a();
        rom_a[0] = ea(3, 1, 0, 0, 8'h42);
        rom_a[1] = ea(1, 0, 1, 0, 0);
        rom_a[2] = ea(0, 2, 0, 1, 0);
        reset_a();
        step(8);
        check("stall_before_rst", {pc_a, outs_a}, {8'd2, 16'h0042});
        rst_a = 1'b0;
        step(1);
        check("midstall_rst", {pc_a, ra_a, halt_a, ack_a, ov_a, outs_a, regs_a}, 0);
        rst_a = 1'b1;

        // wide instance
        for (int i = 0; i < 256; i++) rom_b[i] = eb(7, 0, 0, 0, 0);
        rom_b[0] = eb(3, 1, 0, 0, 5);
        rom_b[1] = eb(3, 2, 0, 0, 3);
        rom_b[2] = eb(2, 3, 1, 2, 0);
        rom_b[3] = eb(2, 5, 2, 1, 1);
        rom_b[4] = eb(3, 7, 0, 0, 12'hABC);
        rom_b[5] = eb(0, 6, 0, 3, 0);
        inputs_b = {12'h123, 12'h0, 12'h0, 12'h0};
        inv_b    = 4'b1000;
        @(negedge clk) rst_nb = 1'b0;
        step(2);
        check("b_rst", {pc_b, halt_b, regs_b}, 0);
        rst_nb = 1'b1;
        cyc = 0;
        while (!halt_b && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("b_cycles", cyc, 14);
        check("b_pc", pc_b, 6);
        check("b_regs", regs_b, {12'hABC, 12'h123, 12'hFFE, 12'h0, 12'h8, 12'h3, 12'h5, 12'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_param.md
# cpu_param

Parametrised successor to the 8-bit four-register stripe CPU. Data width, register count, I/O channel count and program address width are all configurable. It adds a two-phase fetch/execute sequencer for a synchronous ROM, a valid/ack handshake on inputs, per-channel output strobes, conditional branches and an explicit HALT instruction. It sits between the program ROM and the input/output stripes, and exposes its register file for the display stripe.

## Interface
Parameters:
- DATA_W, 8, register/data/immediate width
- NREGS, 4, register count (power of 2, ≥2); RW = clog2(NREGS)
- NIN, 2, input channels (≥1)
- NOUT, 2, output channels (≥1); CW = clog2(max(NIN,NOUT,2)), constraint CW ≤ RW
- ADDR_W, 8, program address width, constraint ADDR_W ≤ DATA_W
- derived INSN_W = 3 + 3·RW + DATA_W

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous reset, active low
- rom_value  in  INSN_W  instruction word at rom_address, valid one cycle after rom_address changes
- inputs  in  NIN·DATA_W  input channel data, channel c at [c·DATA_W +: DATA_W]
- in_valid  in  NIN  channel c data available
- in_ack  out  NIN  one-cycle pulse: channel c data consumed
- outputs  out  NOUT·DATA_W  output registers, held until rewritten
- out_valid  out  NOUT  one-cycle pulse on the cycle after channel c was written
- halt  out  1  core stopped
- pc  out  ADDR_W  address of current instruction
- rom_address  out  ADDR_W  registered, always equal to pc
- regs  out  NREGS·DATA_W  register file, reg r at [r·DATA_W +: DATA_W]

## Operation
- Fields: op=[2:0], rd=[3+:RW], rs1=[3+RW+:RW], rs2=[3+2RW+:RW], imm=[3+3RW+:DATA_W]; ch = rs2[CW-1:0].
- Opcodes:
  - 0 IN: wait for in_valid[ch], then rd←inputs[ch] and in_ack[ch] pulse.
  - 1 OUT: outputs[ch]←rs1.
  - 2 MATH: sub-op is imm[1:0]; 0 ADD, 1 SUB, 2 AND, 3 XOR; rd←rs1 op rs2.
  - 3 IMM: rd←imm.
  - 4 JMP: pc←imm[ADDR_W-1:0].
  - 5 BEQZ: if rs1==0, pc←imm[ADDR_W-1:0].
  - 6 BNEZ: if rs1≠0, pc←imm[ADDR_W-1:0].
  - 7 HALT: halt←1; pc unchanged.
- Non-jumping instructions: pc←pc+1, mod 2^ADDR_W; 2^ADDR_W−1 wraps to 0.
- Arithmetic is modulo 2^DATA_W; no flags, no carry.
- Register indices ≥ NREGS read as 0; writes to them are dropped.
- IN on a channel ≥ NIN writes 0 to rd without stalling and raises no ack.
- OUT on a channel ≥ NOUT is a no-op and raises no strobe.
- rd may equal rs1/rs2; operands are read before the write.
- FSM:
  - FETCH: one cycle, ROM latency; → EXEC.
  - EXEC: decode rom_value and commit. Goes → FETCH, except HALT → HALTED, and IN with in_valid[ch]=0, which stays in EXEC (stall).
  - HALTED: absorbing; all state frozen until reset.

## Timing
- Reset (rst_n=0 at an edge, any state including mid-stall): pc=0, rom_address=0, regs=0, outputs=0, halt=0, in_ack=0, out_valid=0, state=FETCH. Reset takes priority over every other event.
- Non-stalling instruction: 2 cycles. pc and rom_address update on the EXEC edge, together.
- IN: completes on the first EXEC edge where in_valid[ch]=1. in_ack[ch] is high for exactly the following cycle. Cost is 2 + stall cycles.
- out_valid[ch] is high for the single cycle after the write edge. outputs[ch] is already new in that cycle.
- halt rises on the HALT EXEC edge. pc then stays at the HALT's address, and in_ack and out_valid stay 0.
- in_valid changes during FETCH are ignored. Only EXEC samples in_valid.

## Test plan
- Reset/run, defaults: reset, then IMM r1←5, IMM r2←3, MATH ADD r3←r1+r2, HALT. Required: regs = {0,8,3,5} (r3..r0), halt=1 at cycle 8, pc=3.
- Arithmetic wrap: r1=0x02, r2=0x05. SUB gives 0xFD, ADD 0xFF+0x01 gives 0x00, AND 0xF0&0x3C gives 0x30, XOR 0xF0^0x3C gives 0xCC.
- Branch loop: r1=3; loop of SUB r1←r1−r2 (r2=1) and BNEZ r1 back to the SUB, then HALT. Required: exits with r1=0 after 3 iterations; BEQZ on r1=0 is taken. pc wraps 0xFF→0x00 for a non-jump instruction at 0xFF.
- IN handshake: IN r1 from ch1 with in_valid=0 for 5 cycles, then inputs[ch1]=0xA7 and in_valid[1]=1. Required: stall for 5 cycles, r1=0xA7, one-cycle in_ack[1], no ack on ch0.
- OUT strobe: OUT ch0←r1=0x42. Required: outputs[7:0]=0x42, single-cycle out_valid[0]. OUT to ch ≥ NOUT leaves outputs unchanged with no strobe.
- Reset mid-stall and reparametrisation: pull rst_n low while stalled in IN; all outputs return to reset values on the next edge. Repeat the first scenario with DATA_W=12, NREGS=8, NIN=4, NOUT=4.
